// File: rtl/tdm_demux_1x8_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tdm_demux_1x8_pkg
// Purpose  : Shared constants and types for the 8-slot TDM link. Both the
//            receive-side demux and the transmit-side framer use them.
// Revision : 1.0 - initial release
// ============================================================================
package tdm_demux_1x8_pkg;

   // Bits per channel word
   localparam int WIDTH = 4;
   // Channels per frame. This value is fixed, so the slot index is 3 bits.
   localparam int N_CH  = 8;

   // Index of a slot within a frame
   typedef logic [2:0] slot_t;

   // Frame alignment state
   typedef enum logic [0:0] {
      HUNT = 1'b0,
      RECV = 1'b1
   } state_t;

endpackage : tdm_demux_1x8_pkg
`default_nettype wire

// File: rtl/tdm_demux_1x8.sv
`default_nettype none
// ============================================================================
// Module   : tdm_demux_1x8
// Purpose  : Splits a time-multiplexed 4-bit word stream back onto eight
//            parallel channels. Words 0..6 of a frame are collected in a
//            staging bank. When word 7 arrives, the staged words and word 7
//            go to o0..o7 on the same clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tdm_demux_1x8
   import tdm_demux_1x8_pkg::*;
#(
   parameter int WIDTH = tdm_demux_1x8_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   input  logic             sof,
   output logic [WIDTH-1:0] o0,
   output logic [WIDTH-1:0] o1,
   output logic [WIDTH-1:0] o2,
   output logic [WIDTH-1:0] o3,
   output logic [WIDTH-1:0] o4,
   output logic [WIDTH-1:0] o5,
   output logic [WIDTH-1:0] o6,
   output logic [WIDTH-1:0] o7,
   output logic             frame_valid,
   output logic             locked,
   output logic             sync_err,
   output slot_t            slot
);

   // The slot index of the last word of a frame
   localparam slot_t c_LAST_SLOT = slot_t'(N_CH - 1);

   state_t           r_state;
   // Only slots 0..6 are staged. The last word goes straight to o7.
   logic [WIDTH-1:0] r_staging [N_CH-1];

   // Frame alignment FSM. It also drives the slot counter, the staging bank
   // and the registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= HUNT;
         slot        <= '0;
         locked      <= 1'b0;
         frame_valid <= 1'b0;
         sync_err    <= 1'b0;
         o0 <= '0; o1 <= '0; o2 <= '0; o3 <= '0;
         o4 <= '0; o5 <= '0; o6 <= '0; o7 <= '0;
         for (int i = 0; i < N_CH - 1; i++) begin
            r_staging[i] <= '0;
         end
      end else begin
         // frame_valid and sync_err are single-cycle pulses
         frame_valid <= 1'b0;
         sync_err    <= 1'b0;
         case (r_state)
            HUNT: begin
               if (din_valid) begin
                  if (sof) begin
                     r_staging[0] <= din;
                     slot         <= slot_t'(1);
                     r_state      <= RECV;
                  end else if (locked) begin
                     // A good frame was not followed by sof: alignment is lost
                     sync_err <= 1'b1;
                     locked   <= 1'b0;
                  end
               end
            end
            RECV: begin
               if (din_valid) begin
                  if (sof) begin
                     // Truncated frame. This word restarts the frame at slot 0.
                     sync_err     <= 1'b1;
                     locked       <= 1'b0;
                     r_staging[0] <= din;
                     slot         <= slot_t'(1);
                  end else if (slot == c_LAST_SLOT) begin
                     o0 <= r_staging[0];
                     o1 <= r_staging[1];
                     o2 <= r_staging[2];
                     o3 <= r_staging[3];
                     o4 <= r_staging[4];
                     o5 <= r_staging[5];
                     o6 <= r_staging[6];
                     o7 <= din;
                     frame_valid <= 1'b1;
                     locked      <= 1'b1;
                     slot        <= '0;
                     r_state     <= HUNT;
                  end else begin
                     r_staging[slot] <= din;
                     slot            <= slot + slot_t'(1);
                  end
               end
            end
            default: begin
               r_state <= HUNT;
               slot    <= '0;
            end
         endcase
      end
   end

endmodule : tdm_demux_1x8
`default_nettype wire

// File: tb/tb_tdm_demux_1x8.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdm_demux_1x8
// Purpose  : Self-checking bench for tdm_demux_1x8. A queue-based model of
//            the framing rules predicts the outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdm_demux_1x8;
   import tdm_demux_1x8_pkg::*;

   logic             clk       = 1'b0;
   logic             rst_n     = 1'b0;
   logic [WIDTH-1:0] din       = '0;
   logic             din_valid = 1'b0;
   logic             sof       = 1'b0;
   logic [WIDTH-1:0] o0, o1, o2, o3, o4, o5, o6, o7;
   logic             frame_valid, locked, sync_err;
   slot_t            slot;

   int total = 0;
   int bad   = 0;

   // Reference model state. m_cur holds the words of the open frame and is
   // empty while hunting for sof.
   logic [WIDTH-1:0]      m_cur [$];
   logic [N_CH*WIDTH-1:0] m_outs;
   logic                  m_fv, m_serr, m_locked;

   wire [N_CH*WIDTH-1:0] outs = {o7, o6, o5, o4, o3, o2, o1, o0};
   wire [N_CH*WIDTH+5:0] st   = {outs, frame_valid, sync_err, locked, slot};

   tdm_demux_1x8 #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sof(sof),
      .o0(o0), .o1(o1), .o2(o2), .o3(o3), .o4(o4), .o5(o5), .o6(o6), .o7(o7),
      .frame_valid(frame_valid), .locked(locked), .sync_err(sync_err),
      .slot(slot)
   );

   always #5 clk = ~clk;

   function automatic logic [N_CH*WIDTH+5:0] exp_st();
      return {m_outs, m_fv, m_serr, m_locked, slot_t'(m_cur.size())};
   endfunction

   task automatic model_reset();
      m_cur.delete();
      m_outs   = '0;
      m_fv     = 1'b0;
      m_serr   = 1'b0;
      m_locked = 1'b0;
   endtask

   // Drive one cycle of stimulus at the negative edge. Apply the framing
   // rules to the model at the positive edge. Return 1 ns after that edge.
   task automatic step(input logic v, input logic s, input logic [WIDTH-1:0] d);
      @(negedge clk);
      din_valid = v;
      sof       = s;
      din       = d;
      @(posedge clk);
      m_fv   = 1'b0;
      m_serr = 1'b0;
      if (v) begin
         if (s) begin
            if (m_cur.size() != 0) begin
               m_serr   = 1'b1;
               m_locked = 1'b0;
            end
            m_cur.delete();
            m_cur.push_back(d);
         end else if (m_cur.size() == 0) begin
            if (m_locked) begin
               m_serr   = 1'b1;
               m_locked = 1'b0;
            end
         end else begin
            m_cur.push_back(d);
            if (m_cur.size() == N_CH) begin
               for (int i = 0; i < N_CH; i++) m_outs[i*WIDTH +: WIDTH] = m_cur[i];
               m_fv     = 1'b1;
               m_locked = 1'b1;
               m_cur.delete();
            end
         end
      end
      #1;
   endtask

   task automatic test_reset();
      model_reset();
      #2;
      total++;
      if (st !== '0) begin
         bad++;
         $display("FAIL reset_state got=%h exp=0", st);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      for (int k = 0; k < N_CH; k++) begin
         step(1'b1, k == 0, WIDTH'(k + 1));
         total++;
         if (st !== exp_st()) begin
            bad++;
            $display("FAIL single_step%0d got=%h exp=%h", k, st, exp_st());
         end
      end
      total++;
      if (outs !== 32'h8765_4321 || frame_valid !== 1'b1 || locked !== 1'b1) begin
         bad++;
         $display("FAIL single_publish outs=%h fv=%b lk=%b exp outs=87654321 fv=1 lk=1",
                  outs, frame_valid, locked);
      end
      step(1'b0, 1'b0, '0);
      total++;
      if (frame_valid !== 1'b0) begin
         bad++;
         $display("FAIL single_fv_width got=%b exp=0", frame_valid);
      end
   endtask

   task automatic test_gapped();
      for (int k = 0; k < N_CH; k++) begin
         step(1'b0, 1'b1, 4'hF);
         total++;
         if (st !== exp_st()) begin
            bad++;
            $display("FAIL gapped_idle%0d got=%h exp=%h", k, st, exp_st());
         end
         step(1'b1, k == 0, WIDTH'(N_CH - k));
         total++;
         if (st !== exp_st()) begin
            bad++;
            $display("FAIL gapped_word%0d got=%h exp=%h", k, st, exp_st());
         end
      end
      total++;
      if (outs !== 32'h1234_5678 || frame_valid !== 1'b1) begin
         bad++;
         $display("FAIL gapped_publish outs=%h fv=%b exp outs=12345678 fv=1", outs, frame_valid);
      end
   endtask

   task automatic test_truncation();
      for (int k = 0; k < 5; k++) step(1'b1, k == 0, 4'h3);
      step(1'b1, 1'b1, 4'hA);
      total++;
      if (sync_err !== 1'b1 || locked !== 1'b0 || slot !== 3'd1 || outs !== 32'h1234_5678) begin
         bad++;
         $display("FAIL trunc_err serr=%b lk=%b slot=%0d outs=%h exp 1 0 1 12345678",
                  sync_err, locked, slot, outs);
      end
      for (int k = 1; k < N_CH; k++) begin
         step(1'b1, 1'b0, WIDTH'(k));
         total++;
         if (st !== exp_st()) begin
            bad++;
            $display("FAIL trunc_refill%0d got=%h exp=%h", k, st, exp_st());
         end
      end
      total++;
      if (o0 !== 4'hA || frame_valid !== 1'b1) begin
         bad++;
         $display("FAIL trunc_publish o0=%h fv=%b exp o0=a fv=1", o0, frame_valid);
      end
   endtask

   task automatic test_missing_sof();
      logic [N_CH*WIDTH-1:0] prev;
      prev = outs;
      step(1'b1, 1'b0, 4'h5);
      total++;
      if (sync_err !== 1'b1 || locked !== 1'b0 || outs !== prev || slot !== 3'd0) begin
         bad++;
         $display("FAIL nosof_err serr=%b lk=%b slot=%0d outs=%h exp 1 0 0 %h",
                  sync_err, locked, slot, outs, prev);
      end
      step(1'b1, 1'b0, 4'h6);
      total++;
      if (st !== exp_st() || sync_err !== 1'b0) begin
         bad++;
         $display("FAIL nosof_unlocked got=%h exp=%h", st, exp_st());
      end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 3 * N_CH; k++) begin
         step(1'b1, (k % N_CH) == 0, WIDTH'($urandom));
         total++;
         if (st !== exp_st() || frame_valid !== ((k % N_CH) == N_CH - 1) || sync_err !== 1'b0) begin
            bad++;
            $display("FAIL b2b_cycle%0d got=%h exp=%h", k + 1, st, exp_st());
         end
      end
   endtask

   task automatic test_random();
      logic v, s;
      for (int k = 0; k < 400; k++) begin
         v = ($urandom_range(3) != 0);
         s = (m_cur.size() == 0) ? ($urandom_range(7) != 0) : ($urandom_range(15) == 0);
         step(v, s, WIDTH'($urandom));
         total++;
         if (st !== exp_st() || (frame_valid && sync_err)) begin
            bad++;
            $display("FAIL random_cycle%0d got=%h exp=%h", k, st, exp_st());
         end
      end
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < N_CH; k++) step(1'b1, k == 0, WIDTH'(k + 2));
      step(1'b1, 1'b1, 4'h3);
      step(1'b1, 1'b0, 4'h4);
      @(negedge clk);
      din_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      total++;
      if (st !== '0) begin
         bad++;
         $display("FAIL reset_mid got=%h exp=0", st);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 1'b0, 4'h7);
      total++;
      if (st !== exp_st()) begin
         bad++;
         $display("FAIL reset_after got=%h exp=%h", st, exp_st());
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_gapped();
      test_truncation();
      test_missing_sof();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_tdm_demux_1x8
`default_nettype wire
